neuron_train_ctrl: RTL and testbench

Sequencer for one learning neuron (forward neuron + back-propagation datapath, both combinational). Accepts one training or inference sample per valid/ready handshake and loads the dendrites. It waits for the forward path to settle, then computes and drives the error, and pulses the weight-commit strobe. It returns the pre-update axon value over a second handshake, and also owns the learning-rate configuration (mul/div) and epoch counting.

---
 rtl/ntc_pkg.sv | 25 ++
 rtl/ntc_epoch_counter.sv | 63 ++++++
 rtl/neuron_train_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_neuron_train_ctrl.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ntc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ntc_pkg
// Description : Shared types and constants for the neuron training sequencer.
//               Holds the FSM state encoding, the learning-rate reset values
//               and the width of the settle-cycle counter.
// Revision    : 1.0 - initial release
// ============================================================================
package ntc_pkg;

  typedef enum logic [2:0] {
    NTC_IDLE   = 3'd0,
    NTC_LOAD   = 3'd1,
    NTC_FWD    = 3'd2,
    NTC_BP     = 3'd3,
    NTC_COMMIT = 3'd4,
    NTC_OUT    = 3'd5
  } ntc_state_t;

  localparam int NTC_MUL_RESET = 1;
  localparam int NTC_DIV_RESET = 1;
  localparam int NTC_SETTLE_W  = 4;

endpackage
`default_nettype wire

// File: rtl/ntc_epoch_counter.sv
`default_nettype none
// ============================================================================
// Module      : ntc_epoch_counter
// Description : Counts committed training samples and completed epochs.
//               The sample count wraps at P-1; the epoch count saturates at
//               all-ones. epoch_done_o is combinational so that it lines up
//               with the commit strobe that completes the epoch.
// Ports       : clk_i, rst_ni            - clock, async active-low reset
//               commit_i                 - one-cycle training commit strobe
//               samples_per_epoch_i      - P, 0 disables counting
//               epoch_count_o            - completed epochs (saturating)
//               epoch_done_o             - pulse with the epoch-ending commit
// Revision    : 1.0 - initial release
// ============================================================================
module ntc_epoch_counter #(
  parameter int EPOCH_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               commit_i,
  input  logic [EPOCH_W-1:0] samples_per_epoch_i,
  output logic [EPOCH_W-1:0] epoch_count_o,
  output logic               epoch_done_o
);

  logic [EPOCH_W-1:0] sample_cnt_q, sample_cnt_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               count_en;
  logic               wrap;

  assign count_en = commit_i && (samples_per_epoch_i != '0);
  assign wrap     = count_en && (sample_cnt_q == (samples_per_epoch_i - EPOCH_W'(1)));

  always_comb begin
    sample_cnt_d = sample_cnt_q;
    epoch_d      = epoch_q;
    if (count_en) begin
      if (wrap) begin
        sample_cnt_d = '0;
        if (epoch_q != '1) begin
          epoch_d = epoch_q + EPOCH_W'(1);
        end
      end else begin
        sample_cnt_d = sample_cnt_q + EPOCH_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sample_cnt_q <= '0;
      epoch_q      <= '0;
    end else begin
      sample_cnt_q <= sample_cnt_d;
      epoch_q      <= epoch_d;
    end
  end

  assign epoch_count_o = epoch_q;
  assign epoch_done_o  = wrap;

endmodule
`default_nettype wire

// File: rtl/neuron_train_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : neuron_train_ctrl
// Description : Sequencer for one learning neuron. Accepts a sample, strobes
//               the dendrite load, waits for the forward path to settle,
//               captures axon and error, optionally waits for backprop to
//               settle and strobes the weight commit, then hands the captured
//               axon out over a valid/ready handshake. Also owns the
//               learning-rate multiplier/divisor and epoch counting.
// Ports       : ntc_clock / ntc_reset_n              - clock, async low reset
//               ntc_sample_valid/ready, train_en,
//               ntc_target                           - sample handshake
//               ntc_dendrite_load, ntc_axon,
//               ntc_backprop, ntc_weight_commit      - neuron datapath control
//               ntc_cfg_we/mul/div,
//               ntc_training_mul/div                 - learning-rate config
//               ntc_result_valid/ready, ntc_result   - result handshake
//               ntc_samples_per_epoch, epoch_count,
//               ntc_epoch_done, ntc_busy             - epoch stats and status
// Revision    : 1.0 - initial release
// ============================================================================
module neuron_train_ctrl
  import ntc_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 2,
  parameter int EPOCH_W       = 16
) (
  input  logic               ntc_clock,
  input  logic               ntc_reset_n,
  input  logic               ntc_sample_valid,
  output logic               ntc_sample_ready,
  input  logic               ntc_train_en,
  input  logic [DATA_W-1:0]  ntc_target,
  output logic               ntc_dendrite_load,
  input  logic [DATA_W-1:0]  ntc_axon,
  output logic [DATA_W-1:0]  ntc_backprop,
  output logic               ntc_weight_commit,
  output logic [DATA_W-1:0]  ntc_training_mul,
  output logic [DATA_W-1:0]  ntc_training_div,
  input  logic               ntc_cfg_we,
  input  logic [DATA_W-1:0]  ntc_cfg_mul,
  input  logic [DATA_W-1:0]  ntc_cfg_div,
  input  logic [EPOCH_W-1:0] ntc_samples_per_epoch,
  output logic               ntc_result_valid,
  input  logic               ntc_result_ready,
  output logic [DATA_W-1:0]  ntc_result,
  output logic [EPOCH_W-1:0] ntc_epoch_count,
  output logic               ntc_epoch_done,
  output logic               ntc_busy
);

  localparam logic [NTC_SETTLE_W-1:0] SETTLE_LAST = NTC_SETTLE_W'(SETTLE_CYCLES - 1);

  ntc_state_t              state_q, state_d;
  logic [NTC_SETTLE_W-1:0] settle_q, settle_d;
  logic                    train_q, train_d;
  logic [DATA_W-1:0]       target_q, target_d;
  logic [DATA_W-1:0]       result_q, result_d;
  logic [DATA_W-1:0]       backprop_q, backprop_d;
  logic [DATA_W-1:0]       mul_q, mul_d;
  logic [DATA_W-1:0]       div_q, div_d;
  logic                    pend_q, pend_d;
  logic [DATA_W-1:0]       pend_mul_q, pend_mul_d;
  logic [DATA_W-1:0]       pend_div_q, pend_div_d;
  logic                    cfg_ok;

  // A zero divisor would be meaningless downstream, so such writes are dropped.
  assign cfg_ok = ntc_cfg_we && (ntc_cfg_div != '0);

  always_comb begin
    state_d    = state_q;
    settle_d   = settle_q;
    train_d    = train_q;
    target_d   = target_q;
    result_d   = result_q;
    backprop_d = backprop_q;
    mul_d      = mul_q;
    div_d      = div_q;
    pend_d     = pend_q;
    pend_mul_d = pend_mul_q;
    pend_div_d = pend_div_q;

    case (state_q)
      NTC_IDLE: begin
        if (ntc_sample_valid) begin
          train_d  = ntc_train_en;
          target_d = ntc_target;
          state_d  = NTC_LOAD;
        end
      end
      NTC_LOAD: begin
        settle_d = '0;
        state_d  = NTC_FWD;
      end
      NTC_FWD: begin
        if (settle_q == SETTLE_LAST) begin
          // Forward path has settled: capture output and error together.
          result_d   = ntc_axon;
          backprop_d = target_q - ntc_axon;
          settle_d   = '0;
          state_d    = train_q ? NTC_BP : NTC_OUT;
        end else begin
          settle_d = settle_q + NTC_SETTLE_W'(1);
        end
      end
      NTC_BP: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = NTC_COMMIT;
        end else begin
          settle_d = settle_q + NTC_SETTLE_W'(1);
        end
      end
      NTC_COMMIT: state_d = NTC_OUT;
      NTC_OUT: begin
        if (ntc_result_ready) begin
          state_d = NTC_IDLE;
        end
      end
      default: state_d = NTC_IDLE;
    endcase

    // Learning rate: direct update while idle, otherwise shadowed so the
    // datapath sees a constant rate for the whole sample.
    if (state_q == NTC_IDLE) begin
      if (cfg_ok) begin
        mul_d = ntc_cfg_mul;
        div_d = ntc_cfg_div;
      end
    end else begin
      if (cfg_ok) begin
        pend_d     = 1'b1;
        pend_mul_d = ntc_cfg_mul;
        pend_div_d = ntc_cfg_div;
      end
      if (state_d == NTC_IDLE) begin
        if (pend_d) begin
          mul_d = pend_mul_d;
          div_d = pend_div_d;
        end
        pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge ntc_clock or negedge ntc_reset_n) begin
    if (!ntc_reset_n) begin
      state_q    <= NTC_IDLE;
      settle_q   <= '0;
      train_q    <= 1'b0;
      target_q   <= '0;
      result_q   <= '0;
      backprop_q <= '0;
      mul_q      <= DATA_W'(NTC_MUL_RESET);
      div_q      <= DATA_W'(NTC_DIV_RESET);
      pend_q     <= 1'b0;
      pend_mul_q <= '0;
      pend_div_q <= '0;
    end else begin
      state_q    <= state_d;
      settle_q   <= settle_d;
      train_q    <= train_d;
      target_q   <= target_d;
      result_q   <= result_d;
      backprop_q <= backprop_d;
      mul_q      <= mul_d;
      div_q      <= div_d;
      pend_q     <= pend_d;
      pend_mul_q <= pend_mul_d;
      pend_div_q <= pend_div_d;
    end
  end

  assign ntc_sample_ready  = (state_q == NTC_IDLE);
  assign ntc_dendrite_load = (state_q == NTC_LOAD);
  assign ntc_weight_commit = (state_q == NTC_COMMIT);
  assign ntc_result_valid  = (state_q == NTC_OUT);
  assign ntc_busy          = (state_q != NTC_IDLE);
  assign ntc_result        = result_q;
  assign ntc_backprop      = backprop_q;
  assign ntc_training_mul  = mul_q;
  assign ntc_training_div  = div_q;

  // COMMIT is only reachable by training samples, so inference never counts.
  ntc_epoch_counter #(
    .EPOCH_W (EPOCH_W)
  ) u_epoch (
    .clk_i               (ntc_clock),
    .rst_ni              (ntc_reset_n),
    .commit_i            (ntc_weight_commit),
    .samples_per_epoch_i (ntc_samples_per_epoch),
    .epoch_count_o       (ntc_epoch_count),
    .epoch_done_o        (ntc_epoch_done)
  );

endmodule
`default_nettype wire

// File: tb/tb_neuron_train_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_neuron_train_ctrl
// Description : Self-checking bench for neuron_train_ctrl. Directed and random
//               samples are checked cycle by cycle against expectations built
//               from the sample timeline (S = settle cycles), the error rule
//               target - axon, the learning-rate shadow rule and an epoch
//               model based on commit totals.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_train_ctrl;

  localparam int DATA_W  = 32;
  localparam int S       = 2;
  localparam int EPOCH_W = 16;

  logic               ntc_clock = 1'b0;
  logic               ntc_reset_n;
  logic               ntc_sample_valid;
  logic               ntc_sample_ready;
  logic               ntc_train_en;
  logic [DATA_W-1:0]  ntc_target;
  logic               ntc_dendrite_load;
  logic [DATA_W-1:0]  ntc_axon;
  logic [DATA_W-1:0]  ntc_backprop;
  logic               ntc_weight_commit;
  logic [DATA_W-1:0]  ntc_training_mul;
  logic [DATA_W-1:0]  ntc_training_div;
  logic               ntc_cfg_we;
  logic [DATA_W-1:0]  ntc_cfg_mul;
  logic [DATA_W-1:0]  ntc_cfg_div;
  logic [EPOCH_W-1:0] ntc_samples_per_epoch;
  logic               ntc_result_valid;
  logic               ntc_result_ready;
  logic [DATA_W-1:0]  ntc_result;
  logic [EPOCH_W-1:0] ntc_epoch_count;
  logic               ntc_epoch_done;
  logic               ntc_busy;

  neuron_train_ctrl #(
    .DATA_W        (DATA_W),
    .SETTLE_CYCLES (S),
    .EPOCH_W       (EPOCH_W)
  ) dut (
    .ntc_clock             (ntc_clock),
    .ntc_reset_n           (ntc_reset_n),
    .ntc_sample_valid      (ntc_sample_valid),
    .ntc_sample_ready      (ntc_sample_ready),
    .ntc_train_en          (ntc_train_en),
    .ntc_target            (ntc_target),
    .ntc_dendrite_load     (ntc_dendrite_load),
    .ntc_axon              (ntc_axon),
    .ntc_backprop          (ntc_backprop),
    .ntc_weight_commit     (ntc_weight_commit),
    .ntc_training_mul      (ntc_training_mul),
    .ntc_training_div      (ntc_training_div),
    .ntc_cfg_we            (ntc_cfg_we),
    .ntc_cfg_mul           (ntc_cfg_mul),
    .ntc_cfg_div           (ntc_cfg_div),
    .ntc_samples_per_epoch (ntc_samples_per_epoch),
    .ntc_result_valid      (ntc_result_valid),
    .ntc_result_ready      (ntc_result_ready),
    .ntc_result            (ntc_result),
    .ntc_epoch_count       (ntc_epoch_count),
    .ntc_epoch_done        (ntc_epoch_done),
    .ntc_busy              (ntc_busy)
  );

  always #5 ntc_clock = ~ntc_clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  logic [DATA_W-1:0]  exp_mul, exp_div;
  bit                 pend_valid;
  logic [DATA_W-1:0]  pend_mul, pend_div;
  int                 seg_commits;
  logic [EPOCH_W-1:0] exp_epochs;
  int                 n_done_pulses;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge ntc_clock);
    #1;
  endtask

  task automatic model_reset();
    exp_mul     = 1;
    exp_div     = 1;
    pend_valid  = 0;
    pend_mul    = '0;
    pend_div    = '0;
    seg_commits = 0;
    exp_epochs  = '0;
  endtask

  task automatic cfg_idle(input logic [DATA_W-1:0] m, input logic [DATA_W-1:0] d);
    ntc_cfg_we  = 1'b1;
    ntc_cfg_mul = m;
    ntc_cfg_div = d;
    tick();
    ntc_cfg_we  = 1'b0;
    if (d != 0) begin
      exp_mul = m;
      exp_div = d;
    end
    check("cfg_idle_mul", ntc_training_mul, exp_mul);
    check("cfg_idle_div", ntc_training_div, exp_div);
  endtask

  // One complete sample, starting and ending in IDLE just after an edge.
  task automatic run_sample(input bit train, input logic [DATA_W-1:0] tgt,
                            input logic [DATA_W-1:0] ax, input int hold,
                            input bit cfg_bp, input logic [DATA_W-1:0] cmul,
                            input logic [DATA_W-1:0] cdiv);
    logic [DATA_W-1:0] err;
    bit exp_done;
    err = tgt - ax;
    check("idle_ready", ntc_sample_ready, 1);
    check("idle_busy", ntc_busy, 0);
    ntc_sample_valid = 1'b1;
    ntc_train_en     = train;
    ntc_target       = tgt;
    ntc_axon         = ~ax;
    tick();
    // LOAD cycle: target/train_en must already be latched
    ntc_sample_valid = 1'b0;
    ntc_target       = $urandom;
    ntc_train_en     = $urandom_range(0, 1);
    ntc_result_ready = $urandom_range(0, 1);
    check("load_strobe", ntc_dendrite_load, 1);
    check("load_ready", ntc_sample_ready, 0);
    check("load_busy", ntc_busy, 1);
    check("load_commit", ntc_weight_commit, 0);
    for (int k = 1; k <= S; k++) begin
      tick();
      check("fwd_load", ntc_dendrite_load, 0);
      check("fwd_rvalid", ntc_result_valid, 0);
      check("fwd_commit", ntc_weight_commit, 0);
      // only the final forward cycle carries the settled axon
      ntc_axon = (k == S) ? ax : $urandom;
    end
    tick();
    ntc_axon = $urandom;
    if (train) begin
      for (int k = 1; k <= S; k++) begin
        check("bp_backprop", ntc_backprop, err);
        check("bp_commit", ntc_weight_commit, 0);
        check("bp_rvalid", ntc_result_valid, 0);
        check("bp_mul", ntc_training_mul, exp_mul);
        check("bp_div", ntc_training_div, exp_div);
        ntc_cfg_we  = cfg_bp && (k == 1);
        ntc_cfg_mul = cmul;
        ntc_cfg_div = cdiv;
        if (cfg_bp && k == 1 && cdiv != 0) begin
          pend_valid = 1;
          pend_mul   = cmul;
          pend_div   = cdiv;
        end
        tick();
      end
      ntc_cfg_we = 1'b0;
      exp_done = 0;
      if (ntc_samples_per_epoch != 0) begin
        seg_commits++;
        exp_done = (seg_commits % int'(ntc_samples_per_epoch)) == 0;
        if (exp_done && exp_epochs != '1) exp_epochs++;
      end
      check("commit_strobe", ntc_weight_commit, 1);
      check("commit_backprop", ntc_backprop, err);
      check("commit_epoch_done", ntc_epoch_done, exp_done);
      check("commit_mul", ntc_training_mul, exp_mul);
      check("commit_div", ntc_training_div, exp_div);
      if (exp_done) n_done_pulses++;
      tick();
    end
    ntc_result_ready = 1'b0;
    check("out_rvalid", ntc_result_valid, 1);
    check("out_result", ntc_result, ax);
    check("out_backprop", ntc_backprop, err);
    check("out_commit", ntc_weight_commit, 0);
    check("out_epoch_done", ntc_epoch_done, 0);
    check("out_epoch_count", ntc_epoch_count, exp_epochs);
    ntc_sample_valid = 1'b1;
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_rvalid", ntc_result_valid, 1);
      check("hold_result", ntc_result, ax);
      check("hold_ready", ntc_sample_ready, 0);
      check("hold_load", ntc_dendrite_load, 0);
    end
    ntc_result_ready = 1'b1;
    tick();
    ntc_result_ready = 1'b0;
    ntc_sample_valid = 1'b0;
    if (pend_valid) begin
      exp_mul = pend_mul;
      exp_div = pend_div;
    end
    pend_valid = 0;
    check("post_ready", ntc_sample_ready, 1);
    check("post_rvalid", ntc_result_valid, 0);
    check("post_busy", ntc_busy, 0);
    check("post_mul", ntc_training_mul, exp_mul);
    check("post_div", ntc_training_div, exp_div);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DATA_W-1:0] t, a, d;
    bit tr, cb;
    ntc_reset_n           = 1'b0;
    ntc_sample_valid      = 1'b0;
    ntc_train_en          = 1'b0;
    ntc_target            = '0;
    ntc_axon              = '0;
    ntc_cfg_we            = 1'b0;
    ntc_cfg_mul           = '0;
    ntc_cfg_div           = '0;
    ntc_samples_per_epoch = '0;
    ntc_result_ready      = 1'b0;
    n_done_pulses         = 0;
    model_reset();
    tick();
    tick();
    check("rst_ready", ntc_sample_ready, 1);
    check("rst_busy", ntc_busy, 0);
    check("rst_load", ntc_dendrite_load, 0);
    check("rst_commit", ntc_weight_commit, 0);
    check("rst_rvalid", ntc_result_valid, 0);
    check("rst_result", ntc_result, 0);
    check("rst_backprop", ntc_backprop, 0);
    check("rst_mul", ntc_training_mul, 1);
    check("rst_div", ntc_training_div, 1);
    check("rst_epoch", ntc_epoch_count, 0);
    check("rst_epoch_done", ntc_epoch_done, 0);
    ntc_reset_n = 1'b1;
    tick();

    // Inference and training directed samples
    run_sample(0, 32'h0000_0077, 32'h10, 0, 0, 0, 0);
    run_sample(1, 32'h64, 32'h28, 1, 0, 0, 0);
    run_sample(1, 32'h0, 32'h5, 0, 0, 0, 0);
    check("neg_backprop", ntc_backprop, 32'hFFFF_FFFB);

    // Config shadowing while busy, then an ignored zero-divisor write
    run_sample(1, 32'h1234, 32'h34, 0, 1, 32'd3, 32'd4);
    check("cfg_mul_3", ntc_training_mul, 3);
    check("cfg_div_4", ntc_training_div, 4);
    cfg_idle(32'd9, 32'd0);
    run_sample(1, $urandom, $urandom, 0, 1, 32'd11, 32'd0);
    check("cfg_div0_mul", ntc_training_mul, 3);
    cfg_idle(32'd7, 32'd5);

    // Epochs with P = 3
    ntc_samples_per_epoch = 16'd3;
    n_done_pulses = 0;
    for (int i = 0; i < 7; i++)
      run_sample(1, $urandom, $urandom, $urandom_range(0, 2), 0, 0, 0);
    check("epoch_p3_count", ntc_epoch_count, 2);
    check("epoch_p3_pulses", n_done_pulses, 2);
    run_sample(0, $urandom, $urandom, 0, 0, 0, 0);
    check("epoch_infer_count", ntc_epoch_count, 2);

    // P = 0 disables counting
    ntc_samples_per_epoch = 16'd0;
    n_done_pulses = 0;
    for (int i = 0; i < 3; i++)
      run_sample(1, $urandom, $urandom, 0, 0, 0, 0);
    check("epoch_p0_pulses", n_done_pulses, 0);
    check("epoch_p0_count", ntc_epoch_count, 2);

    // Backpressure: result held for 10 cycles with a sample waiting
    run_sample(0, $urandom, 32'hCAFE_F00D, 10, 0, 0, 0);

    // Reset mid-sample, with a pending config write that must be discarded
    ntc_sample_valid = 1'b1;
    ntc_train_en     = 1'b1;
    ntc_target       = 32'h500;
    tick();
    ntc_sample_valid = 1'b0;
    ntc_cfg_we       = 1'b1;
    ntc_cfg_mul      = 32'd13;
    ntc_cfg_div      = 32'd17;
    tick();
    ntc_cfg_we = 1'b0;
    for (int k = 1; k <= S; k++) tick();
    check("pre_rst_in_bp", ntc_busy, 1);
    #2 ntc_reset_n = 1'b0;
    #1;
    check("mid_rst_commit", ntc_weight_commit, 0);
    check("mid_rst_busy", ntc_busy, 0);
    check("mid_rst_backprop", ntc_backprop, 0);
    check("mid_rst_result", ntc_result, 0);
    check("mid_rst_epoch", ntc_epoch_count, 0);
    check("mid_rst_mul", ntc_training_mul, 1);
    check("mid_rst_div", ntc_training_div, 1);
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_hold_commit", ntc_weight_commit, 0);
    end
    ntc_reset_n = 1'b1;
    tick();
    run_sample(1, 32'h40, 32'h10, 0, 0, 0, 0);
    check("after_rst_mul", ntc_training_mul, 1);

    // Randomised traffic with P = 2
    ntc_samples_per_epoch = 16'd2;
    n_done_pulses = 0;
    for (int i = 0; i < 24; i++) begin
      tr = $urandom_range(0, 1);
      t  = $urandom;
      a  = $urandom;
      cb = $urandom_range(0, 1);
      d  = ($urandom_range(0, 3) == 0) ? '0 : DATA_W'($urandom_range(1, 1000));
      run_sample(tr, t, a, $urandom_range(0, 3), cb, $urandom, d);
    end
    check("rand_epoch_count", ntc_epoch_count, exp_epochs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
